ntsc_timing_gen: RTL and testbench
==================================

// Module: ntsc_timing_gen
// PURPOSE
//  Raster timing source for the NTSC shield. Divides the 50 MHz clk into a pixel tick.
//  Runs horizontal and vertical counters for a 262-line progressive (240p) frame.
//  Drives x/y/active_video into the pattern/text generators, and sync/burst into the CVBS encoder.
// PARAMETERS
//  CLK_DIV   4    clk cycles per pixel (12.5 MHz pixel rate)
//  H_ACTIVE  640  active pixels per line
//  H_FRONT   19   front-porch pixels
//  H_SYNC    59   hsync pixels (4.72 us)
//  H_BACK    76   back-porch pixels; H_TOTAL = 794 (63.52 us line)
//  BURST_OFS 7    burst start, in pixels after hsync end
//  BURST_LEN 31   burst width in pixels (2.48 us)
//  V_ACTIVE  240  active lines
//  V_FRONT   3    front-porch lines
//  V_SYNC    3    vsync lines
//  V_BACK    16   back-porch lines; V_TOTAL = 262
// PORTS
//  clk          in   1   50 MHz clock
//  rst_n        in   1   asynchronous active-low reset
//  en           in   1   run enable; low = hold raster at origin
//  pixel_tick   out  1   one-clk strobe, once per CLK_DIV clks
//  x            out  10  horizontal count h_cnt, 0..H_TOTAL-1
//  y            out  9   vertical count v_cnt, 0..V_TOTAL-1
//  active_video out  1   high when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE
//  hsync_n      out  1   low during the horizontal sync interval
//  vsync_n      out  1   low during the vertical sync lines
//  csync_n      out  1   composite sync, ~(hsync ^ vsync)
//  burst        out  1   colour-burst gate
//  frame_start  out  1   one-clk pulse when the raster enters (0,0)
// BEHAVIOUR
//  - Reset (async assert, sync deassert) values:
//    - div_cnt=0, h_cnt=0, v_cnt=0.
//    - pixel_tick=0, x=0, y=0, active_video=0, frame_start=0, burst=0.
//    - hsync_n=1, vsync_n=1, csync_n=1.
//  - Pixel divider:
//    - div_cnt counts 0..CLK_DIV-1 while en=1.
//    - pixel_tick=1 for exactly the clk where div_cnt==CLK_DIV-1.
//  - Raster advance, on each clk edge where pixel_tick=1:
//    - h_cnt increments and wraps from H_TOTAL-1 to 0.
//    - On the h_cnt wrap, v_cnt increments and wraps from V_TOTAL-1 to 0.
//  - Output registers:
//    - All outputs except pixel_tick are registers decoded from the NEXT counter values.
//    - They change on the same edge as the counters and stay constant for CLK_DIV clks.
//    - This gives downstream stages CLK_DIV-1 clks for a 1-cycle font ROM read.
//  - Horizontal regions, in h_cnt:
//    - Active: [0, 640).
//    - Front porch: [640, 659).
//    - Sync: [659, 718); hsync_n=0.
//    - Back porch: [718, 794).
//  - Vertical regions, in v_cnt:
//    - Active: [0, 240).
//    - Front porch: [240, 243).
//    - Sync: [243, 246); vsync_n=0 for entire lines.
//    - Back porch: [246, 262).
//  - csync_n: inverted (serrated broad pulse) during vsync lines.
//  - burst=1 for h_cnt in [725, 756), only when vsync_n=1.
//  - frame_start=1 for the first clk of the CLK_DIV window where h_cnt=0 and v_cnt=0.
//    - Asserted after every V_TOTAL wrap.
//    - Also asserted on the first tick after reset or en rise.
//  - en=0, sampled at any clk, on the next edge:
//    - div_cnt, h_cnt and v_cnt go to 0.
//    - Outputs return to their reset values.
//    - This applies mid-line and mid-frame; no partial line completes.
//  - en rising: the first pixel_tick follows CLK_DIV clks later.
//  - Reset mid-frame: outputs take reset values immediately (async).
//  - Static width checks: H_TOTAL<=1024, V_TOTAL<=512, CLK_DIV>=2.
//    - Any violation fails elaboration via a generate-time $error.
// TESTING
//  1. Reset held, then released, en=1 -> all outputs at reset values; first pixel_tick at clk 4 after release.
//  2. Free run one line -> hsync_n low for 236 clks at a 3176-clk period.
//     - burst high for 124 clks, starting 28 clks after hsync_n rises.
//  3. Free run one frame -> active_video high for 153600 pixel ticks, only on lines y<240.
//     - vsync_n low for 3*3176 clks; frame_start once per 832112 clks.
//  4. Wrap check -> x steps 793 to 0 and y 239 to 240 on the same edge.
//     - x 793 to 0 with y 261 to 0 produces frame_start.
//  5. Deassert en at x=300, y=100 for 10 clks -> next edge x=0, y=0, hsync_n=1, no ticks.
//     - After re-enable, raster restarts at the origin with frame_start.
//  6. Assert rst_n=0 mid-clk during vsync -> vsync_n/csync_n go high without waiting for clk.

Source files
------------

// File: rtl/ntsc_timing_gen.sv
// NTSC 240p raster timing: pixel-rate divider, h/v counters and registered sync,
// burst, active-video and frame-start decode for the pattern generators and CVBS encoder.
module ntsc_timing_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FRONT   = 19,
    parameter int unsigned H_SYNC    = 59,
    parameter int unsigned H_BACK    = 76,
    parameter int unsigned BURST_OFS = 7,
    parameter int unsigned BURST_LEN = 31,
    parameter int unsigned V_ACTIVE  = 240,
    parameter int unsigned V_FRONT   = 3,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BACK    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       pixel_tick,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       active_video,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       csync_n,
    output logic       burst,
    output logic       frame_start
);

    localparam int unsigned X_W          = 10;
    localparam int unsigned Y_W          = 9;
    localparam int unsigned DIV_W        = $clog2(CLK_DIV);
    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned BURST_START  = H_SYNC_END + BURST_OFS;
    localparam int unsigned BURST_END    = BURST_START + BURST_LEN;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    if (H_TOTAL > 1024) begin : g_bad_h_total
        $error("ntsc_timing_gen: H_TOTAL exceeds 10-bit x range");
    end
    if (V_TOTAL > 512) begin : g_bad_v_total
        $error("ntsc_timing_gen: V_TOTAL exceeds 9-bit y range");
    end
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("ntsc_timing_gen: CLK_DIV must be at least 2");
    end

    // IDLE: raster parked at origin; the first tick enters (0,0) without advancing.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [X_W-1:0]     h_cnt_q, h_cnt_d;
    logic [Y_W-1:0]     v_cnt_q, v_cnt_d;
    logic               pixel_tick_q, pixel_tick_d;
    logic               active_q, active_d;
    logic               hsync_n_q, hsync_n_d;
    logic               vsync_n_q, vsync_n_d;
    logic               csync_n_q, csync_n_d;
    logic               burst_q, burst_d;
    logic               frame_start_q, frame_start_d;
    logic               h_sync_c, v_sync_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pixel_tick_q  <= 1'b0;
            active_q      <= 1'b0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            csync_n_q     <= 1'b1;
            burst_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pixel_tick_q  <= pixel_tick_d;
            active_q      <= active_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            csync_n_q     <= csync_n_d;
            burst_q       <= burst_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Outputs are decoded from the next counter values so they align with x/y.
    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pixel_tick_d  = 1'b0;
        active_d      = active_q;
        hsync_n_d     = hsync_n_q;
        vsync_n_d     = vsync_n_q;
        csync_n_d     = csync_n_q;
        burst_d       = burst_q;
        frame_start_d = 1'b0;
        h_sync_c      = 1'b0;
        v_sync_c      = 1'b0;

        if (!en) begin
            state_d   = ST_IDLE;
            div_cnt_d = '0;
            h_cnt_d   = '0;
            v_cnt_d   = '0;
            active_d  = 1'b0;
            hsync_n_d = 1'b1;
            vsync_n_d = 1'b1;
            csync_n_d = 1'b1;
            burst_d   = 1'b0;
        end else begin
            if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
            pixel_tick_d = (div_cnt_d == DIV_W'(CLK_DIV - 1));

            if (pixel_tick_q) begin
                state_d = ST_RUN;
                if (state_q == ST_RUN) begin
                    if (h_cnt_q == X_W'(H_TOTAL - 1)) begin
                        h_cnt_d = '0;
                        if (v_cnt_q == Y_W'(V_TOTAL - 1)) begin
                            v_cnt_d = '0;
                        end else begin
                            v_cnt_d = v_cnt_q + Y_W'(1);
                        end
                    end else begin
                        h_cnt_d = h_cnt_q + X_W'(1);
                    end
                end

                h_sync_c      = (h_cnt_d >= X_W'(H_SYNC_START)) && (h_cnt_d < X_W'(H_SYNC_END));
                v_sync_c      = (v_cnt_d >= Y_W'(V_SYNC_START)) && (v_cnt_d < Y_W'(V_SYNC_END));
                active_d      = (h_cnt_d < X_W'(H_ACTIVE)) && (v_cnt_d < Y_W'(V_ACTIVE));
                hsync_n_d     = ~h_sync_c;
                vsync_n_d     = ~v_sync_c;
                csync_n_d     = ~(h_sync_c ^ v_sync_c);
                burst_d       = ~v_sync_c && (h_cnt_d >= X_W'(BURST_START))
                                && (h_cnt_d < X_W'(BURST_END));
                frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
            end
        end
    end

    assign pixel_tick   = pixel_tick_q;
    assign x            = h_cnt_q;
    assign y            = v_cnt_q;
    assign active_video = active_q;
    assign hsync_n      = hsync_n_q;
    assign vsync_n      = vsync_n_q;
    assign csync_n      = csync_n_q;
    assign burst        = burst_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_ntsc_timing_gen.sv
// Self-checking bench for ntsc_timing_gen: closed-form raster model feeding a per-clock
// scoreboard, plus line/frame/wrap/enable/reset scenario checks. Short frame keeps runtime low.
module tb_ntsc_timing_gen;

    localparam int DIV   = 4;
    localparam int HA    = 640;
    localparam int HF    = 19;
    localparam int HS    = 59;
    localparam int HB    = 76;
    localparam int HT    = HA + HF + HS + HB;
    localparam int VA    = 4;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int VT    = VA + VF + VS + VB;
    localparam int LINE  = DIV * HT;
    localparam int FRAME = LINE * VT;

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [8:0] y;
        logic       av;
        logic       hs;
        logic       vs;
        logic       cs;
        logic       bu;
        logic       fs;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       pixel_tick;
    logic [9:0] x;
    logic [8:0] y;
    logic       active_video;
    logic       hsync_n;
    logic       vsync_n;
    logic       csync_n;
    logic       burst;
    logic       frame_start;

    obs_t q[$];
    int   k      = 0;
    int   errors = 0;
    int   checks = 0;

    ntsc_timing_gen #(
        .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .BURST_OFS(7), .BURST_LEN(31),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pixel_tick(pixel_tick), .x(x), .y(y),
        .active_video(active_video), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .csync_n(csync_n), .burst(burst), .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // kk = clock edges since reset release / en rise; pixel n-1 is shown after n ticks.
    function automatic obs_t model(input int kk);
        obs_t m;
        int n, p, h, v;
        logic hsy, vsy;
        m      = '0;
        m.tick = (kk % DIV) == DIV - 1;
        m.hs   = 1'b1;
        m.vs   = 1'b1;
        m.cs   = 1'b1;
        n = kk / DIV;
        if (n > 0) begin
            p    = n - 1;
            h    = p % HT;
            v    = (p / HT) % VT;
            hsy  = (h >= 659) && (h < 718);
            vsy  = (v >= VA + VF) && (v < VA + VF + VS);
            m.x  = 10'(h);
            m.y  = 9'(v);
            m.av = (h < HA) && (v < VA);
            m.hs = !hsy;
            m.vs = !vsy;
            m.cs = !(hsy ^ vsy);
            m.bu = !vsy && (h >= 725) && (h < 756);
            m.fs = ((kk % DIV) == 0) && (h == 0) && (v == 0);
        end
        return m;
    endfunction

    function automatic obs_t dut_obs();
        return obs_t'({pixel_tick, x, y, active_video, hsync_n, vsync_n, csync_n, burst, frame_start});
    endfunction

    always @(posedge clk) begin
        if (!rst_n || !en) k = 0;
        else               k = k + 1;
        q.push_back(model(k));
    end

    task automatic step(output obs_t e);
        @(negedge clk);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
            e = '0;
        end else begin
            e = q.pop_front();
        end
    endtask

    task automatic test_reset();
        obs_t e, o, rst_v;
        int first_tick, first_fs;
        rst_v = obs_t'({1'b0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        rst_n = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(e);
            o = dut_obs();
            checks++;
            if (o !== rst_v) begin
                errors++;
                $display("FAIL reset_values: got %h required %h", o, rst_v);
            end
        end
        rst_n      = 1'b1;
        first_tick = -1;
        first_fs   = -1;
        for (int i = 0; i < 12; i++) begin
            step(e);
            o = dut_obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_release_trace cyc %0d: got %h required %h", i, o, e);
            end
            if (o.tick && first_tick < 0) first_tick = i;
            if (o.fs && first_fs < 0) first_fs = i;
        end
        checks++;
        if (first_tick + 2 !== 4) begin
            errors++;
            $display("FAIL first_tick_clk: tick consumed at edge %0d required 4", first_tick + 2);
        end
        checks++;
        if (first_fs + 1 !== 4) begin
            errors++;
            $display("FAIL first_frame_start: seen after edge %0d required 4", first_fs + 1);
        end
    endtask

    task automatic test_line();
        obs_t e;
        int t, f0, r0, f1, b_r, b_f;
        logic phs, pbu;
        t = 0; f0 = -1; r0 = -1; f1 = -1; b_r = -1; b_f = -1;
        phs = hsync_n;
        pbu = burst;
        for (int i = 0; i < 3 * LINE; i++) begin
            step(e);
            t++;
            if (phs && !hsync_n) begin
                if (f0 < 0)      f0 = t;
                else if (f1 < 0) f1 = t;
            end
            if (!phs && hsync_n && f0 >= 0 && r0 < 0) r0 = t;
            if (!pbu && burst && r0 >= 0 && b_r < 0) b_r = t;
            if (pbu && !burst && b_r >= 0 && b_f < 0) b_f = t;
            phs = hsync_n;
            pbu = burst;
            if (f1 >= 0) break;
        end
        checks++;
        if (r0 - f0 !== 236) begin
            errors++;
            $display("FAIL hsync_width: got %0d clks required 236", r0 - f0);
        end
        checks++;
        if (f1 - f0 !== LINE) begin
            errors++;
            $display("FAIL hsync_period: got %0d clks required %0d", f1 - f0, LINE);
        end
        checks++;
        if (b_r - r0 !== 28) begin
            errors++;
            $display("FAIL burst_offset: got %0d clks required 28", b_r - r0);
        end
        checks++;
        if (b_f - b_r !== 124) begin
            errors++;
            $display("FAIL burst_width: got %0d clks required 124", b_f - b_r);
        end
    endtask

    task automatic test_wrap();
        obs_t e, o, prev;
        bit seen_va, done;
        int ey;
        seen_va = 1'b0;
        done    = 1'b0;
        prev    = dut_obs();
        for (int i = 0; i < FRAME + LINE; i++) begin
            step(e);
            o = dut_obs();
            if (o.x != prev.x && prev.x == 10'd793) begin
                ey = (int'(prev.y) + 1) % VT;
                checks++;
                if (o.x !== 10'd0 || o.y !== 9'(ey)) begin
                    errors++;
                    $display("FAIL wrap_step: got x=%0d y=%0d required x=0 y=%0d", o.x, o.y, ey);
                end
                if (prev.y == 9'(VA - 1)) seen_va = 1'b1;
                if (prev.y == 9'(VT - 1)) begin
                    checks++;
                    if (o.fs !== 1'b1) begin
                        errors++;
                        $display("FAIL wrap_frame_start: got %0b required 1", o.fs);
                    end
                    done = 1'b1;
                end
            end
            prev = o;
            if (done) break;
        end
        checks++;
        if (!(seen_va && done)) begin
            errors++;
            $display("FAIL wrap_timeout: active_end=%0b frame_wrap=%0b required both 1", seen_va, done);
        end
    endtask

    task automatic test_frame();
        obs_t e, o, fb_o, fb_e;
        int mism, act, act_bad, vlow, fs_n, fs_at;
        mism = 0; act = 0; act_bad = 0; vlow = 0; fs_n = 0; fs_at = -1;
        fb_o = '0; fb_e = '0;
        for (int i = 0; i < FRAME; i++) begin
            step(e);
            o = dut_obs();
            if (o !== e) begin
                if (mism == 0) begin
                    fb_o = o;
                    fb_e = e;
                end
                mism++;
            end
            if (o.av && o.tick) act++;
            if (o.av && (o.y >= 9'(VA) || o.x >= 10'(HA))) act_bad++;
            if (!o.vs) vlow++;
            if (o.fs) begin
                fs_n++;
                fs_at = i;
            end
        end
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL frame_trace: %0d clks differ, first got %h required %h", mism, fb_o, fb_e);
        end
        checks++;
        if (act !== HA * VA) begin
            errors++;
            $display("FAIL active_ticks: got %0d required %0d", act, HA * VA);
        end
        checks++;
        if (act_bad !== 0) begin
            errors++;
            $display("FAIL active_outside: got %0d clks required 0", act_bad);
        end
        checks++;
        if (vlow !== VS * LINE) begin
            errors++;
            $display("FAIL vsync_low: got %0d clks required %0d", vlow, VS * LINE);
        end
        checks++;
        if (fs_n !== 1 || fs_at !== FRAME - 1) begin
            errors++;
            $display("FAIL frame_period: got %0d pulses last at %0d required 1 at %0d", fs_n, fs_at, FRAME - 1);
        end
    endtask

    task automatic test_enable();
        obs_t e, o;
        bit found;
        int ticks, fs_i;
        found = 1'b0;
        for (int i = 0; i < 2 * LINE; i++) begin
            step(e);
            if (x == 10'd300 && y == 9'd1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL en_position_timeout: x=%0d y=%0d required x=300 y=1", x, y);
        end
        en = 1'b0;
        step(e);
        o = dut_obs();
        checks++;
        if (o.x !== 10'd0 || o.y !== 9'd0 || o.hs !== 1'b1 || o.fs !== 1'b0) begin
            errors++;
            $display("FAIL en_low_origin: got x=%0d y=%0d hsync_n=%0b fs=%0b required 0 0 1 0",
                     o.x, o.y, o.hs, o.fs);
        end
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL en_low_state: got %h required %h", o, e);
        end
        ticks = o.tick ? 1 : 0;
        for (int i = 1; i < 10; i++) begin
            step(e);
            if (pixel_tick) ticks++;
        end
        checks++;
        if (ticks !== 0) begin
            errors++;
            $display("FAIL en_low_ticks: got %0d required 0", ticks);
        end
        en   = 1'b1;
        fs_i = -1;
        for (int i = 0; i < 8; i++) begin
            step(e);
            o = dut_obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL en_restart_trace cyc %0d: got %h required %h", i, o, e);
            end
            if (o.fs && fs_i < 0) fs_i = i;
        end
        checks++;
        if (fs_i + 1 !== 4) begin
            errors++;
            $display("FAIL en_restart_frame_start: after edge %0d required 4", fs_i + 1);
        end
    endtask

    task automatic test_reset_vsync();
        obs_t e, o, rst_v;
        int fs_i;
        rst_v = obs_t'({1'b0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < VT * LINE; i++) begin
            step(e);
            if (!vsync_n && !hsync_n) break;
        end
        checks++;
        if (vsync_n !== 1'b0 || csync_n !== 1'b1) begin
            errors++;
            $display("FAIL vsync_reach: vsync_n=%0b csync_n=%0b required 0 1", vsync_n, csync_n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (vsync_n !== 1'b1 || csync_n !== 1'b1 || hsync_n !== 1'b1 || x !== 10'd0 || y !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: vsync_n=%0b csync_n=%0b hsync_n=%0b x=%0d y=%0d required 1 1 1 0 0",
                     vsync_n, csync_n, hsync_n, x, y);
        end
        step(e);
        o = dut_obs();
        checks++;
        if (o !== rst_v) begin
            errors++;
            $display("FAIL async_reset_hold: got %h required %h", o, rst_v);
        end
        rst_n = 1'b1;
        fs_i  = -1;
        for (int i = 0; i < 8; i++) begin
            step(e);
            o = dut_obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL post_reset_trace cyc %0d: got %h required %h", i, o, e);
            end
            if (o.fs && fs_i < 0) fs_i = i;
        end
        checks++;
        if (fs_i + 1 !== 4) begin
            errors++;
            $display("FAIL post_reset_frame_start: after edge %0d required 4", fs_i + 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        test_reset();
        test_line();
        test_wrap();
        test_frame();
        test_enable();
        test_reset_vsync();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
